// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MDU_MADD_EN
  logic        acc_q, acc_d;
`endif

  // Operands are extended to 64 bits; the low 64 bits of the product are
  // correct for both signed and unsigned interpretations.
  logic [63:0] a_ext, b_ext, prod, mul_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    a_ext = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext = {{32{sgn_q & b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
`ifdef MDU_MADD_EN
    mul_res = acc_q ? (prod + {hi_q, lo_q}) : prod;
`else
    mul_res = prod;
`endif
  end

  // Signed division via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    a_neg  = sgn_q & a_q[31];
    b_neg  = sgn_q & b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = A;
              b_d     = B;
              sgn_d   = (op == OP_MULT);
              cnt_d   = 4'(MULT_CYCLES);
              state_d = MUL;
              busy_d  = 1'b1;
`ifdef MDU_MADD_EN
              acc_d   = 1'b0;
`endif
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              a_d     = A;
              b_d     = B;
              sgn_d   = (op == OP_MADD);
              acc_d   = 1'b1;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = MUL;
              busy_d  = 1'b1;
            end
`endif
            OP_DIV, OP_DIVU: begin
              a_d     = A;
              b_d     = B;
              sgn_d   = (op == OP_DIV);
              cnt_d   = 4'(DIV_CYCLES);
              state_d = DIV;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          busy_d  = 1'b0;
          if (state_q == MUL) begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO results.
// Expectations for the MADDU sequence follow whether MDU_MADD_EN is defined.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO;

  int nCompared = 0;
  int nMismatched = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts busy cycles sampled on falling edges, bounded so a stuck busy cannot hang the run.
  task automatic waitIdle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Launches one operation, scrambles the operands right after the start edge, waits for idle.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0; A = 32'hDEADBEEF; B = 32'h13579BDF;
    waitIdle(cyc);
  endtask

  initial begin
    int cyc;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    reset = 1'b1;

    applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, cyc);
    checkOutput("mult_busy", cyc, 32'd5);
    checkOutput("mult_hi", HI, 32'hFFFFFFFF);
    checkOutput("mult_lo", LO, 32'hFFFFFFFA);

    applyStimulus(4'd2, 32'hFFFFFFFE, 32'd3, cyc);
    checkOutput("multu_busy", cyc, 32'd5);
    checkOutput("multu_hi", HI, 32'h00000002);
    checkOutput("multu_lo", LO, 32'hFFFFFFFA);

    applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, cyc);
    checkOutput("div_busy", cyc, 32'd10);
    checkOutput("div_lo", LO, 32'hFFFFFFFD);
    checkOutput("div_hi", HI, 32'hFFFFFFFF);

    applyStimulus(4'd4, 32'd7, 32'd2, cyc);
    checkOutput("divu_lo", LO, 32'd3);
    checkOutput("divu_hi", HI, 32'd1);

    applyStimulus(4'd3, 32'd7, 32'hFFFFFFFE, cyc);
    checkOutput("div_negdivisor_lo", LO, 32'hFFFFFFFD);
    checkOutput("div_negdivisor_hi", HI, 32'd1);

    applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, cyc);
    checkOutput("div_ovf_lo", LO, 32'h80000000);
    checkOutput("div_ovf_hi", HI, 32'd0);

    applyStimulus(4'd5, 32'h12345678, 32'd0, cyc);
    checkOutput("mthi_busy", cyc, 32'd0);
    checkOutput("mthi_hi", HI, 32'h12345678);
    checkOutput("mthi_lo_kept", LO, 32'h80000000);

    applyStimulus(4'd3, 32'd5, 32'd0, cyc);
    checkOutput("divzero_busy", cyc, 32'd10);
    checkOutput("divzero_hi", HI, 32'h12345678);
    checkOutput("divzero_lo", LO, 32'h80000000);

    applyStimulus(4'd9, 32'h55, 32'h66, cyc);
    checkOutput("illegal_busy", cyc, 32'd0);
    checkOutput("illegal_hi", HI, 32'h12345678);
    checkOutput("illegal_lo", LO, 32'h80000000);

    // DIV 100/7 with an MTLO and operand change injected on the third busy cycle.
    @(negedge clk);
    start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b1; op = 4'd6; A = 32'hAAAA; B = 32'd3;
      end else begin
        start = 1'b0; op = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; op = 4'd0;
    checkOutput("busy_ignore_cycles", cyc, 32'd10);
    checkOutput("busy_ignore_lo", LO, 32'd14);
    checkOutput("busy_ignore_hi", HI, 32'd2);

    // Reset asserted on the fourth busy cycle of a DIV, then MULTU on the first edge after release.
    @(negedge clk);
    start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_hi", HI, 32'd0);
    checkOutput("midreset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 4'd2; A = 32'd2; B = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    waitIdle(cyc);
    checkOutput("post_reset_busy", cyc, 32'd5);
    checkOutput("post_reset_hi", HI, 32'd0);
    checkOutput("post_reset_lo", LO, 32'd6);

    applyStimulus(4'd5, 32'd0, 32'd0, cyc);
    applyStimulus(4'd6, 32'hFFFFFFFF, 32'd0, cyc);
    applyStimulus(4'd8, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
    checkOutput("maddu_busy", cyc, 32'd5);
    checkOutput("maddu_hi", HI, 32'd1);
    checkOutput("maddu_lo", LO, 32'd0);
`else
    checkOutput("maddu_busy", cyc, 32'd0);
    checkOutput("maddu_hi", HI, 32'd0);
    checkOutput("maddu_lo", LO, 32'hFFFFFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
